vai_tx_arb: RTL and testbench

- Round-robin arbiter that shares one CCI-P Tx request channel (c0 or c1, chosen by DATA_WIDTH at instantiation) among NUM_SUB_AFUS virtual-AFU requesters.
- Sits between the per-VM Tx ports and the manager's upstream Tx FIFO.
- Buffers each requester in a small FIFO and keeps multi-beat write packets contiguous.
- Tags every beat with its source vmid for the offset auditor.

---
 rtl/vai_tx_arb.sv | 150 +++++++++++++++
 tb/tb_vai_tx_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vai_tx_arb.sv
// Round-robin arbiter sharing one CCI-P Tx channel among NUM_SUB_AFUS buffered requesters,
// keeping multi-beat packets contiguous. Define VAI_TX_ARB_STATS_EN for per-requester grant counters.
module vai_tx_arb #(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int DATA_WIDTH    = 552,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SUB_AFUS-1:0]              in_valid,
  input  logic [NUM_SUB_AFUS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_SUB_AFUS-1:0]              in_last,
  output logic [NUM_SUB_AFUS-1:0]              in_almFull,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [$clog2(NUM_SUB_AFUS)-1:0]      out_vmid,
  input  logic                                 out_almFull,
  output logic [NUM_SUB_AFUS-1:0]              overflow
`ifdef VAI_TX_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_SUB_AFUS)-1:0]      stat_sel,
  output logic [63:0]                          stat_cnt
`endif
);

  localparam int VW = $clog2(NUM_SUB_AFUS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(FIFO_DEPTH - ALMFULL_SLACK);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  logic [DATA_WIDTH:0]     mem_q    [NUM_SUB_AFUS][FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q [NUM_SUB_AFUS];
  logic [PW-1:0]           rd_ptr_q [NUM_SUB_AFUS];
  logic [CW-1:0]           cnt_q    [NUM_SUB_AFUS];
  logic [CW-1:0]           cnt_d    [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] push, pop_vec, not_empty;

  state_e                  state_q;
  logic [VW-1:0]           rr_ptr_q, owner_q, sel, idx;
  logic                    pop;
  logic [DATA_WIDTH:0]     head;

  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) not_empty[i] = (cnt_q[i] != '0);
  end

  // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
  always_comb begin
    sel = owner_q;
    idx = rr_ptr_q;
    pop = 1'b0;
    if (state_q == LOCKED) begin
      pop = not_empty[owner_q] && !out_almFull;
    end else begin
      // Scan farthest-first so the requester nearest the pointer is the one that sticks.
      for (int k = NUM_SUB_AFUS - 1; k >= 0; k--) begin
        idx = rr_ptr_q + VW'(k);
        if (not_empty[idx]) begin
          sel = idx;
          pop = !out_almFull;
        end
      end
    end
  end

  assign head = mem_q[sel][rd_ptr_q[sel]];

  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      pop_vec[i] = pop && (sel == VW'(i));
      // A full FIFO still accepts a beat when its head leaves in the same cycle.
      push[i]    = in_valid[i] && ((cnt_q[i] != FULL_CNT) || pop_vec[i]);
      cnt_d[i]   = cnt_q[i];
      if (push[i] && !pop_vec[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!push[i] && pop_vec[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      in_almFull <= '0;
      overflow   <= '0;
    end else begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        if (push[i])    wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop_vec[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        cnt_q[i]      <= cnt_d[i];
        in_almFull[i] <= (cnt_d[i] >= AF_CNT);
        if (in_valid[i] && !push[i]) overflow[i] <= 1'b1;
      end
    end
  end

  // NOTE: beat storage has no reset; counts and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vmid  <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= head[DATA_WIDTH-1:0];
        out_vmid <= sel;
        if (head[DATA_WIDTH]) begin
          state_q  <= UNLOCKED;
          rr_ptr_q <= sel + VW'(1);
        end else begin
          state_q <= LOCKED;
          owner_q <= sel;
        end
      end
    end
  end

`ifdef VAI_TX_ARB_STATS_EN
  logic [63:0] stat_q [NUM_SUB_AFUS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) stat_q[i] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        if (pop_vec[i]) stat_q[i] <= stat_q[i] + 64'd1;
      end
      stat_cnt <= stat_q[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_vai_tx_arb.sv
// Directed bench for vai_tx_arb: latency, round-robin order, packet lock, backpressure,
// FIFO limits and mid-packet reset, with hand-derived expected beat sequences.
module tb_vai_tx_arb;
  localparam int N  = 8;
  localparam int DW = 552;
  localparam int VW = 3;
  localparam logic [DW-1:0] D_A5 = DW'(8'hA5);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_last, in_almFull, overflow;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_almFull;
  logic [DW-1:0]   out_data;
  logic [VW-1:0]   out_vmid;

  int n_cmp = 0;
  int n_bad = 0;

  vai_tx_arb #(
    .NUM_SUB_AFUS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .ALMFULL_SLACK(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_almFull(in_almFull), .out_valid(out_valid), .out_data(out_data), .out_vmid(out_vmid),
    .out_almFull(out_almFull), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [15:0] v);
    logic [DW-1:0] d;
    d = '0;
    d[15:0] = v;
    d[DW-1 -: 16] = ~v;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
  endtask

  task automatic set_beat(input int r, input logic [DW-1:0] d, input logic l);
    in_valid[r]          = 1'b1;
    in_last[r]           = l;
    in_data[r*DW +: DW]  = d;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b vmid=%0d data=%h, want all zero", out_valid, out_vmid, out_data);
    end
    n_cmp++;
    if ({in_almFull, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_flags: got almFull=%b overflow=%b, want 0/0", in_almFull, overflow);
    end
  endtask

  task automatic test_single_beat();
    clr_inputs();
    set_beat(3, D_A5, 1'b1);
    tick();
    clr_inputs();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early: got out_valid=%b, want 0 one cycle after in_valid", out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd3, D_A5}) begin
      n_bad++;
      $display("FAIL single_beat: got v=%b vmid=%0d data=%h, want v=1 vmid=3 data=a5", out_valid, out_vmid, out_data);
    end
    // Pointer now 4: simultaneous beats from 3 and 4 must grant 4 first.
    set_beat(3, mk(16'h0033), 1'b1);
    set_beat(4, mk(16'h0044), 1'b1);
    tick();
    clr_inputs();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: got out_valid=%b, want 0 after a non-pop", out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd4, mk(16'h0044)}) begin
      n_bad++;
      $display("FAIL pointer_first: got v=%b vmid=%0d data=%h, want vmid=4", out_valid, out_vmid, out_data);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd3, mk(16'h0033)}) begin
      n_bad++;
      $display("FAIL pointer_second: got v=%b vmid=%0d data=%h, want vmid=3", out_valid, out_vmid, out_data);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b0, 3'd3, mk(16'h0033)}) begin
      n_bad++;
      $display("FAIL hold: got v=%b vmid=%0d data=%h, want v=0 with vmid/data held", out_valid, out_vmid, out_data);
    end
  endtask

  task automatic test_fairness();
    logic [VW-1:0] eid;
    logic [DW-1:0] ed;
    for (int c = 0; c < 11; c++) begin
      clr_inputs();
      if (c < 3) begin
        for (int r = 0; r < 3; r++) set_beat(r, mk(16'h0100 + 16'(r * 16) + 16'(c)), 1'b1);
      end
      tick();
      n_cmp++;
      if (c >= 1 && c <= 9) begin
        eid = VW'((c - 1) % 3);
        ed  = mk(16'h0100 + 16'(((c - 1) % 3) * 16) + 16'((c - 1) / 3));
        if ({out_valid, out_vmid, out_data} !== {1'b1, eid, ed}) begin
          n_bad++;
          $display("FAIL fairness_%0d: got v=%b vmid=%0d data=%h, want vmid=%0d data=%h",
                   c - 1, out_valid, out_vmid, out_data, eid, ed);
        end
      end else if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fairness_idle_%0d: got out_valid=%b, want 0", c, out_valid);
      end
    end
  endtask

  // Requester 1 sends a 4-beat packet with 'gap' idle cycles before beat 3; requester 2 waits.
  task automatic test_packet_lock(input int gap);
    logic          ev;
    logic [VW-1:0] eid;
    logic [DW-1:0] ed;
    for (int c = 0; c <= 6 + gap; c++) begin
      clr_inputs();
      if (c == 0) begin
        set_beat(1, mk(16'h0110), 1'b0);
        set_beat(2, mk(16'h02FF), 1'b1);
      end
      if (c == 1)       set_beat(1, mk(16'h0111), 1'b0);
      if (c == 2 + gap) set_beat(1, mk(16'h0112), 1'b0);
      if (c == 3 + gap) set_beat(1, mk(16'h0113), 1'b1);
      tick();
      ev = 1'b1; eid = 3'd1; ed = '0;
      if (c == 1)            ed = mk(16'h0110);
      else if (c == 2)       ed = mk(16'h0111);
      else if (c == 3 + gap) ed = mk(16'h0112);
      else if (c == 4 + gap) ed = mk(16'h0113);
      else if (c == 5 + gap) begin eid = 3'd2; ed = mk(16'h02FF); end
      else ev = 1'b0;
      n_cmp++;
      if (ev) begin
        if ({out_valid, out_vmid, out_data} !== {1'b1, eid, ed}) begin
          n_bad++;
          $display("FAIL lock_g%0d_c%0d: got v=%b vmid=%0d data=%h, want vmid=%0d data=%h",
                   gap, c, out_valid, out_vmid, out_data, eid, ed);
        end
      end else if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL lock_bubble_g%0d_c%0d: got v=%b vmid=%0d, want out_valid=0", gap, c, out_valid, out_vmid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ev;
    int   ek;
    for (int c = 0; c <= 16; c++) begin
      clr_inputs();
      if (c < 5) set_beat(4, mk(16'h0400 + 16'(c)), 1'b1);
      out_almFull = (c >= 2 && c <= 11);
      tick();
      ev = (c == 1) || (c >= 12 && c <= 15);
      ek = (c == 1) ? 0 : c - 11;
      n_cmp++;
      if (ev) begin
        if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd4, mk(16'h0400 + 16'(ek))}) begin
          n_bad++;
          $display("FAIL bp_beat_%0d: got v=%b vmid=%0d data=%h, want vmid=4 beat %0d",
                   c, out_valid, out_vmid, out_data, ek);
        end
      end else if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got out_valid=%b, want 0 while throttled", c, out_valid);
      end
      if (c == 6 || c == 16) begin
        n_cmp++;
        if (in_almFull[4] !== (c == 6)) begin
          n_bad++;
          $display("FAIL bp_almfull_%0d: got in_almFull[4]=%b, want %b", c, in_almFull[4], c == 6);
        end
      end
    end
    out_almFull = 1'b0;
  endtask

  task automatic test_fifo_limits();
    out_almFull = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      clr_inputs();
      set_beat(5, mk(16'h0500 + 16'(k)), 1'b1);
      tick();
      n_cmp++;
      if ({out_valid, in_almFull[5], overflow[5]} !== {1'b0, k >= 4, k >= 9}) begin
        n_bad++;
        $display("FAIL limit_write_%0d: got v=%b almFull=%b ovf=%b, want v=0 almFull=%b ovf=%b",
                 k, out_valid, in_almFull[5], overflow[5], k >= 4, k >= 9);
      end
    end
    clr_inputs();
    out_almFull = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd5, mk(16'h0501 + 16'(j))}) begin
        n_bad++;
        $display("FAIL limit_drain_%0d: got v=%b vmid=%0d data=%h, want vmid=5 data=%h",
                 j, out_valid, out_vmid, out_data, mk(16'h0501 + 16'(j)));
      end
    end
    tick();
    n_cmp++;
    if ({out_valid, in_almFull, overflow} !== {1'b0, 8'h00, 8'h20}) begin
      n_bad++;
      $display("FAIL limit_after: got v=%b almFull=%b ovf=%b, want v=0 almFull=0 ovf=00100000",
               out_valid, in_almFull, overflow);
    end
  endtask

  task automatic test_reset_mid_packet();
    clr_inputs();
    set_beat(1, mk(16'h0610), 1'b0);
    tick();
    clr_inputs();
    set_beat(1, mk(16'h0611), 1'b0);
    set_beat(2, mk(16'h0620), 1'b1);
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd1, mk(16'h0611)}) begin
      n_bad++;
      $display("FAIL mid_beat2: got v=%b vmid=%0d data=%h, want vmid=1 beat 2", out_valid, out_vmid, out_data);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_almFull, overflow} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b almFull=%b ovf=%b, want all zero", out_valid, in_almFull, overflow);
    end
    tick();
    reset = 1'b0;
    set_beat(6, mk(16'h0666), 1'b1);
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({out_valid, out_vmid, out_data} !== {1'b1, 3'd6, mk(16'h0666)}) begin
      n_bad++;
      $display("FAIL post_reset_grant: got v=%b vmid=%0d data=%h, want vmid=6", out_valid, out_vmid, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_empty_%0d: got v=%b vmid=%0d, want out_valid=0", c, out_valid, out_vmid);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    out_almFull = 1'b0;
    clr_inputs();
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single_beat();
    test_fairness();
    test_packet_lock(0);
    test_packet_lock(3);
    test_backpressure();
    test_fifo_limits();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
